iir_stream_seq: RTL and testbench

//   Sequencer for the 16-bit 5th-order IIR filter datapath. Streams samples from

---
 rtl/iir_stream_seq.sv | 147 ++++++++++++++
 tb/tb_iir_stream_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_stream_seq.sv
// Streams samples memory -> IIR core -> memory, one at a time; optional IIR_SEQ_PERF_EN adds cyc_cnt.
// Latency: one sample per 3+RD_LAT+FILT_LAT cycles; the strobes are decoded straight from the state register.
// No backpressure: memories and filter are fixed-latency; start is ignored unless idle or done.
module iir_stream_seq #(
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int FILT_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          load,
  output logic [AW-1:0] RAddr,
  input  logic [DW-1:0] DIn,
  input  logic          data_done,
  output logic          clr_hist,
  output logic [DW-1:0] smp_out,
  output logic          smp_vld,
  input  logic [DW-1:0] y_in,
  output logic          WEN,
  output logic [AW-1:0] WAddr,
  output logic [DW-1:0] Yn,
  output logic          busy,
  output logic          Finish
`ifdef IIR_SEQ_PERF_EN
  ,
  output logic [31:0]   cyc_cnt
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLR       = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_WAIT_RD   = 3'd3;
  localparam logic [2:0] S_FEED      = 3'd4;
  localparam logic [2:0] S_WAIT_FILT = 3'd5;
  localparam logic [2:0] S_WRITE     = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] C_RD   = CW'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  localparam logic [CW-1:0] C_FL   = CW'(FILT_LAT);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_raddr;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_smp;
  logic [DW-1:0] r_yn;
  logic          r_last;
  logic          w_idle;

  assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);

  // FEED is the cycle DIn is on the bus; smp_vld follows once smp_out is registered,
  // and WAIT_FILT then runs FILT_LAT+1 cycles so y_in is sampled in its last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_smp   <= '0;
      r_yn    <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) r_state <= S_CLR;
        end
        S_CLR: begin
          r_idx   <= '0;
          r_raddr <= '0;
          r_state <= S_READ;
        end
        S_READ: begin
          r_cnt   <= C_RD;
          r_state <= (RD_LAT > 1) ? S_WAIT_RD : S_FEED;
        end
        S_WAIT_RD: begin
          if (r_cnt == '0) r_state <= S_FEED;
          else             r_cnt   <= r_cnt - C_ONE;
        end
        S_FEED: begin
          r_smp   <= DIn;
          r_last  <= data_done;
          r_cnt   <= C_FL;
          r_state <= S_WAIT_FILT;
        end
        S_WAIT_FILT: begin
          if (r_cnt == '0) begin
            r_yn    <= y_in;
            r_waddr <= r_idx;
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_WRITE: begin
          // The top address ends the run rather than wrapping back to 0.
          if (r_last || (r_idx == {AW{1'b1}})) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDX_ONE;
            r_raddr <= r_idx + IDX_ONE;
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load     = (r_state == S_READ);
  assign clr_hist = (r_state == S_CLR);
  assign smp_vld  = (r_state == S_WAIT_FILT) && (r_cnt == C_FL);
  assign WEN      = (r_state == S_WRITE);
  assign busy     = !w_idle;
  assign Finish   = (r_state == S_DONE);
  assign RAddr    = r_raddr;
  assign WAddr    = r_waddr;
  assign smp_out  = r_smp;
  assign Yn       = r_yn;

`ifdef IIR_SEQ_PERF_EN
  logic [31:0] r_cyc;

  // Zeroed on start acceptance so the CLR cycle itself is the first one counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc <= '0;
    end else if (w_idle && start) begin
      r_cyc <= '0;
    end else if (busy && (r_cyc != 32'hFFFF_FFFF)) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc;
`endif

endmodule

// File: tb/tb_iir_stream_seq.sv
// Bench for iir_stream_seq: default instance plus an AW=3, RD_LAT=3, FILT_LAT=2 instance.
module tb_iir_stream_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic        load0, clr0, vld0, wen0, busy0, fin0, dd0;
  logic [19:0] ra0, wa0;
  logic [15:0] din0, smp0, y0, yn0;

  logic        load1, clr1, vld1, wen1, busy1, fin1, dd1;
  logic [2:0]  ra1, wa1;
  logic [15:0] din1, smp1, y1, yn1;
`ifdef IIR_SEQ_PERF_EN
  logic [31:0] cc0, cc1;
`endif

  iir_stream_seq u0 (
    .clk(clk), .rst(rst), .start(start0), .load(load0), .RAddr(ra0), .DIn(din0),
    .data_done(dd0), .clr_hist(clr0), .smp_out(smp0), .smp_vld(vld0), .y_in(y0),
    .WEN(wen0), .WAddr(wa0), .Yn(yn0), .busy(busy0), .Finish(fin0)
`ifdef IIR_SEQ_PERF_EN
    , .cyc_cnt(cc0)
`endif
  );

  iir_stream_seq #(.AW(3), .DW(16), .RD_LAT(3), .FILT_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .load(load1), .RAddr(ra1), .DIn(din1),
    .data_done(dd1), .clr_hist(clr1), .smp_out(smp1), .smp_vld(vld1), .y_in(y1),
    .WEN(wen1), .WAddr(wa1), .Yn(yn1), .busy(busy1), .Finish(fin1)
`ifdef IIR_SEQ_PERF_EN
    , .cyc_cnt(cc1)
`endif
  );

  function automatic logic [15:0] s0(input logic [19:0] a);
    return 16'h0100 * (a[15:0] + 16'd1);
  endfunction

  function automatic logic [15:0] s1(input logic [2:0] a);
    return 16'hA000 + 16'h0111 * {13'd0, a};
  endfunction

  // Memory and filter stubs: data is only correct in the exact cycle it is due.
  int last0 = 3;
  int last1 = 1000;
  logic        rv0 = 1'b0;
  logic [19:0] ra0d = '0;
  logic [15:0] yp0 = '0;
  logic [2:0]  rv1 = '0;
  logic [2:0]  ra1d [3];
  logic [15:0] yp1 [2];

  always @(posedge clk) begin
    rv0     <= load0;
    ra0d    <= ra0;
    yp0     <= vld0 ? ~smp0 : 16'h5A5A;
    rv1     <= {rv1[1:0], load1};
    ra1d[0] <= ra1;
    ra1d[1] <= ra1d[0];
    ra1d[2] <= ra1d[1];
    yp1[0]  <= vld1 ? ~smp1 : 16'h5A5A;
    yp1[1]  <= yp1[0];
  end

  assign din0 = rv0 ? s0(ra0d) : 16'hDEAD;
  assign dd0  = rv0 && (int'(ra0d) == last0);
  assign y0   = yp0;
  assign din1 = rv1[2] ? s1(ra1d[2]) : 16'hDEAD;
  assign dd1  = rv1[2] && (int'(ra1d[2]) == last1);
  assign y1   = yp1[1];

  typedef struct {
    int          addr;
    logic [15:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int prev0 = -1, prev1 = -1;
  int nwen0 = 0, nwen1 = 0, nclr0 = 0, nclr1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (clr0) begin nclr0++; prev0 = -1; end
    if (clr1) begin nclr1++; prev1 = -1; end
    if (load0 | vld0 | wen0 | clr0) check("onehot0", $countones({load0, vld0, wen0, clr0}), 1);
    if (load1 | vld1 | wen1 | clr1) check("onehot1", $countones({load1, vld1, wen1, clr1}), 1);
    if (wen0) begin
      nwen0++;
      check("sb_nonempty0", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("waddr0", wa0, e.addr);
        check("yn0", yn0, e.dat);
      end
      if (prev0 >= 0) check("period0", cyc - prev0, 5);
      prev0 = cyc;
    end
    if (wen1) begin
      nwen1++;
      check("sb_nonempty1", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("waddr1", wa1, e.addr);
        check("yn1", yn1, e.dat);
      end
      if (prev1 >= 0) check("period1", cyc - prev1, 8);
      prev1 = cyc;
    end
  end

  task automatic wait_fin0(input int lim);
    for (int i = 0; i < lim && !fin0; i++) @(negedge clk);
  endtask

  task automatic wait_fin1(input int lim);
    for (int i = 0; i < lim && !fin1; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_strobes0", {load0, clr0, vld0, wen0, busy0, fin0}, 0);
    check("rst_raddr0", ra0, 0);
    check("rst_waddr0", wa0, 0);
    check("rst_data0", {smp0, yn0}, 0);
    check("rst_strobes1", {load1, clr1, vld1, wen1, busy1, fin1}, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // Four samples, last flagged on the 4th, plus a start pulse while busy.
    last0 = 3;
    for (int k = 0; k < 4; k++) q0.push_back('{k, ~s0(20'(k))});
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check("clr_pulse_A", clr0, 1);
    check("busy_A", busy0, 1);
    check("fin_low_A", fin0, 0);
    repeat (6) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_fin0(200);
    check("fin_A", fin0, 1);
    check("busy_done_A", busy0, 0);
    check("writes_A", nwen0, 4);
    check("clr_count_A", nclr0, 1);
    check("sb_empty_A", q0.size(), 0);

    // Restart from DONE.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) q0.push_back('{k, ~s0(20'(k))});
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check("fin_drop_B", fin0, 0);
    check("clr_pulse_B", clr0, 1);
    @(negedge clk);
    check("load_B", load0, 1);
    check("raddr_restart_B", ra0, 0);
    wait_fin0(200);
    check("fin_B", fin0, 1);
    check("writes_B", nwen0, 8);
    check("sb_empty_B", q0.size(), 0);

    // Reset asserted while waiting on the filter.
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 20 && !vld0; i++) @(negedge clk);
    check("vld_seen_C", vld0, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_strobes_C", {load0, clr0, vld0, wen0, busy0, fin0}, 0);
    check("abort_waddr_C", wa0, 0);
    check("abort_data_C", {smp0, yn0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_write_after_abort", nwen0, 8);

    // AW=3 instance, data_done never set: must stop at address 7.
    last1 = 1000;
    for (int k = 0; k < 8; k++) q1.push_back('{k, ~s1(3'(k))});
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_fin1(400);
    check("fin_D", fin1, 1);
    check("writes_D", nwen1, 8);
    check("sb_empty_D", q1.size(), 0);
`ifdef IIR_SEQ_PERF_EN
    check("cyc_cnt_D", cc1, 65);
`endif
    repeat (20) @(negedge clk);
    check("no_wrap_D", nwen1, 8);
    check("raddr_hold_D", ra1, 7);

`ifdef IIR_SEQ_PERF_EN
    last1 = 1;
    for (int k = 0; k < 2; k++) q1.push_back('{k, ~s1(3'(k))});
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_fin1(200);
    check("fin_E", fin1, 1);
    check("cyc_cnt_E", cc1, 17);
    check("writes_E", nwen1, 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
